// File: rtl/mem_arbiter.sv
// Grant FSM sharing one memory4c between I-cache fills, D-cache fills
// and D-cache write-through, with word-tagged fill return routing.
module mem_arbiter #(
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic        w_req,
    input  logic [15:0] w_addr,
    input  logic [15:0] w_data,
    output logic        i_busy,
    output logic        d_busy,
    output logic        i_fill_valid,
    output logic        d_fill_valid,
    output logic [2:0]  fill_word,
    output logic [15:0] fill_data,
    output logic        i_done,
    output logic        d_done,
    output logic        w_ack,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_enable,
    output logic        mem_wr,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FILL_I,
        FILL_D
    } state_t;

    state_t      state;
    logic [3:0]  iss;
    logic [2:0]  rcv;
    logic [11:0] base;
    logic        lastFill;
    logic        guardI;
    logic        guardD;
    logic [15:0] memAddr;
    logic        memEnable;
    logic        memWr;
    logic        wAck;

    logic iElig;
    logic dElig;
    logic grantD;
    logic iFill;
    logic dFill;
    logic lastWord;

    // Line offset bits and the latency parameter are not used here.
    logic unusedBits;
    assign unusedBits = ^{i_addr[3:0], d_addr[3:0]} ^ (MEM_LATENCY == 0);

    assign iElig    = i_req & ~guardI;
    assign dElig    = d_req & ~guardD;
    assign grantD   = dElig & (~iElig | lastFill);

    assign iFill    = (state == FILL_I) & mem_data_valid;
    assign dFill    = (state == FILL_D) & mem_data_valid;
    assign lastWord = (rcv == 3'd7);

    assign i_fill_valid = iFill;
    assign d_fill_valid = dFill;
    assign i_done       = iFill & lastWord;
    assign d_done       = dFill & lastWord;
    assign i_busy       = i_req & ~i_done;
    assign d_busy       = d_req & ~d_done;
    assign fill_word    = rcv;
    assign fill_data    = mem_data_out;

    assign mem_addr    = memAddr;
    assign mem_enable  = memEnable;
    assign mem_wr      = memWr;
    assign mem_data_in = w_data;
    assign w_ack       = wAck;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            iss       <= '0;
            rcv       <= '0;
            base      <= '0;
            lastFill  <= 1'b1;
            guardI    <= 1'b0;
            guardD    <= 1'b0;
            memAddr   <= '0;
            memEnable <= 1'b0;
            memWr     <= 1'b0;
            wAck      <= 1'b0;
        end else begin
            memEnable <= 1'b0;
            memWr     <= 1'b0;
            wAck      <= 1'b0;
            unique case (state)
                IDLE: begin
                    guardI <= 1'b0;
                    guardD <= 1'b0;
                    if (w_req) begin
                        state     <= WRITE;
                        memEnable <= 1'b1;
                        memWr     <= 1'b1;
                        memAddr   <= w_addr;
                        wAck      <= 1'b1;
                    end else if (grantD) begin
                        state     <= FILL_D;
                        base      <= d_addr[15:4];
                        memEnable <= 1'b1;
                        memAddr   <= {d_addr[15:4], 4'h0};
                        iss       <= 4'd1;
                    end else if (iElig) begin
                        state     <= FILL_I;
                        base      <= i_addr[15:4];
                        memEnable <= 1'b1;
                        memAddr   <= {i_addr[15:4], 4'h0};
                        iss       <= 4'd1;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                FILL_I, FILL_D: begin
                    // iss holds the index of the next read to present.
                    if (!iss[3]) begin
                        memEnable <= 1'b1;
                        memAddr   <= {base, iss[2:0], 1'b0};
                        iss       <= iss + 4'd1;
                    end
                    if (mem_data_valid) begin
                        rcv <= rcv + 3'd1;
                        if (lastWord) begin
                            state    <= IDLE;
                            iss      <= '0;
                            rcv      <= '0;
                            lastFill <= (state == FILL_I);
                            guardI   <= (state == FILL_I);
                            guardD   <= (state == FILL_D);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner
// sequences and random traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int MEM_LATENCY = 4;
    localparam int MIdle  = 0;
    localparam int MWrite = 1;
    localparam int MFillI = 2;
    localparam int MFillD = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, w_req;
    logic [15:0] i_addr, d_addr, w_addr, w_data;
    logic        i_busy, d_busy, i_fill_valid, d_fill_valid;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        i_done, d_done, w_ack;
    logic [15:0] mem_addr, mem_data_in;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LATENCY(MEM_LATENCY)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data),
        .i_busy(i_busy), .d_busy(d_busy),
        .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
        .fill_word(fill_word), .fill_data(fill_data),
        .i_done(i_done), .d_done(d_done), .w_ack(w_ack),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] memArr [0:65535];
    logic        pendV [0:7];
    logic [15:0] pendD [0:7];
    logic        extraValid;

    int          mMode;
    int          mGrant;
    logic [11:0] mBase;
    int          mRcvd;
    logic        mLastI;
    int          mGuard;

    logic oEn, oWr, oAck, oIFv, oDFv, oIDone, oDDone;
    logic [15:0] oAddr, oDin;
    logic [2:0]  oWord;
    logic pIDone, pDDone, pAck;

    typedef struct {
        logic        rst;
        logic        wReq;
        logic [15:0] wAddr;
        logic [15:0] wData;
        logic        valid;
        logic        expEn;
        logic        expWr;
        logic        expAck;
        logic        chkAddr;
        logic [15:0] expAddr;
    } vec_t;

    vec_t tbl [0:9];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h required %0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        mMode  = MIdle;
        mGrant = 0;
        mBase  = '0;
        mRcvd  = 0;
        mLastI = 1'b1;
        mGuard = MIdle;
    endtask

    task automatic cycle();
        logic eEn, eWr, eAck, eIFv, eDFv, eIDone, eDDone;
        logic [15:0] eAddr;
        logic [2:0]  eWord;
        logic iEl, dEl;
        int k;
        int slot;
        @(negedge clk);
        slot = cyc % 8;
        mem_data_valid = pendV[slot] | extraValid;
        mem_data_out   = pendV[slot] ? pendD[slot] : 16'hDEAD;
        pendV[slot]    = 1'b0;
        #1;
        eEn = 0; eWr = 0; eAck = 0; eIFv = 0; eDFv = 0;
        eIDone = 0; eDDone = 0; eAddr = '0;
        eWord = 3'(mRcvd);
        if (mMode == MWrite) begin
            eEn = 1; eWr = 1; eAck = 1; eAddr = w_addr;
        end else if (mMode == MFillI || mMode == MFillD) begin
            k = cyc - mGrant - 1;
            if (k >= 0 && k < 8) begin
                eEn   = 1;
                eAddr = {mBase, 4'h0} + 16'(2 * k);
            end
            if (mMode == MFillI) eIFv = mem_data_valid;
            else eDFv = mem_data_valid;
            eIDone = eIFv && (mRcvd == 7);
            eDDone = eDFv && (mRcvd == 7);
        end
        check("outputs",
              {mem_enable, mem_wr, w_ack, i_fill_valid, d_fill_valid,
               i_done, d_done, i_busy, d_busy, fill_word,
               (mem_enable ? mem_addr : 16'h0)},
              {eEn, eWr, eAck, eIFv, eDFv, eIDone, eDDone,
               i_req & ~eIDone, d_req & ~eDDone, eWord, eAddr});
        check("data", {fill_data, mem_data_in}, {mem_data_out, w_data});
        oEn = mem_enable; oWr = mem_wr; oAck = w_ack;
        oIFv = i_fill_valid; oDFv = d_fill_valid;
        oIDone = i_done; oDDone = d_done;
        oAddr = mem_addr; oDin = mem_data_in; oWord = fill_word;
        pIDone = eIDone; pDDone = eDDone; pAck = eAck;
        if (rst) begin
            for (int j = 0; j < 8; j++) pendV[j] = 1'b0;
        end else if (mem_enable && !mem_wr) begin
            pendV[(cyc + MEM_LATENCY - 1) % 8] = 1'b1;
            pendD[(cyc + MEM_LATENCY - 1) % 8] = memArr[mem_addr];
        end else if (mem_enable && mem_wr) begin
            memArr[mem_addr] = mem_data_in;
        end
        if (rst) begin
            modelReset();
        end else if (mMode == MIdle) begin
            iEl = i_req && (mGuard != MFillI);
            dEl = d_req && (mGuard != MFillD);
            mGuard = MIdle;
            if (w_req) begin
                mMode = MWrite;
            end else if (dEl && (!iEl || mLastI)) begin
                mMode = MFillD; mGrant = cyc; mBase = d_addr[15:4];
            end else if (iEl) begin
                mMode = MFillI; mGrant = cyc; mBase = i_addr[15:4];
            end
        end else if (mMode == MWrite) begin
            mMode = MIdle;
        end else if (mem_data_valid) begin
            if (mRcvd == 7) begin
                mGuard = mMode;
                mLastI = (mMode == MFillI);
                mMode  = MIdle;
                mRcvd  = 0;
            end else begin
                mRcvd++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst = 1; i_req = 0; d_req = 0; w_req = 0;
        i_addr = 0; d_addr = 0; w_addr = 0; w_data = 0;
        extraValid = 0;
        repeat (2) cycle();
        rst = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] q[$];
        logic [2:0]  wq[$];
        logic [15:0] act;
        logic        prevEn, wRaised, ackWr;
        logic [2:0]  enSeen;
        logic [15:0] ackAddr, ackDin;
        int doneAt, iAct, dDoneAt, iFirst, iDoneAt, ackAt, early, t0;
        logic doneSeen;

        for (int a = 0; a < 65536; a++) memArr[a] = 16'(a * 7 + 16'h1357);
        for (int j = 0; j < 8; j++) begin pendV[j] = 0; pendD[j] = 0; end
        rst = 1; i_req = 0; d_req = 0; w_req = 0;
        i_addr = 0; d_addr = 0; w_addr = 0; w_data = 0;
        extraValid = 0; mem_data_valid = 0; mem_data_out = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;

        tbl[0] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 0, 0, 1, 16'h0000};
        tbl[1] = '{1'b0, 1'b1, 16'h0A0C, 16'hBEEF, 1'b0, 0, 0, 0, 1, 16'h0000};
        tbl[2] = '{1'b0, 1'b1, 16'h0A0C, 16'hBEEF, 1'b0, 1, 1, 1, 1, 16'h0A0C};
        tbl[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 0, 0, 0, 0, 16'h0000};
        tbl[4] = '{1'b0, 1'b1, 16'h1110, 16'h2222, 1'b0, 0, 0, 0, 0, 16'h0000};
        tbl[5] = '{1'b0, 1'b1, 16'h1110, 16'h2222, 1'b1, 1, 1, 1, 1, 16'h1110};
        tbl[6] = '{1'b0, 1'b1, 16'h3330, 16'h4444, 1'b0, 0, 0, 0, 0, 16'h0000};
        tbl[7] = '{1'b0, 1'b1, 16'h3330, 16'h4444, 1'b0, 1, 1, 1, 1, 16'h3330};
        tbl[8] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 0, 0, 0, 0, 16'h0000};
        tbl[9] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 0, 0, 0, 16'h0000};

        resetDut();
        for (int r = 0; r < 10; r++) begin
            rst = tbl[r].rst; w_req = tbl[r].wReq;
            w_addr = tbl[r].wAddr; w_data = tbl[r].wData;
            extraValid = tbl[r].valid;
            cycle();
            check($sformatf("vec%0d", r),
                  {oEn, oWr, oAck, oIFv | oDFv | oIDone | oDDone,
                   (tbl[r].chkAddr ? oAddr : 16'h0)},
                  {tbl[r].expEn, tbl[r].expWr, tbl[r].expAck, 1'b0,
                   (tbl[r].chkAddr ? tbl[r].expAddr : 16'h0)});
        end
        extraValid = 0;

        // Single D fill: address sequence, word tags, done latency.
        resetDut();
        d_req = 1; d_addr = 16'h1234;
        t0 = cyc; doneAt = -1; iAct = 0;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (oEn) q.push_back(oAddr);
            if (oDFv) wq.push_back(oWord);
            if (oIFv | oIDone) iAct++;
            if (oDDone) begin doneAt = cyc - 1 - t0; d_req = 0; end
        end
        check("dfill_count", 64'(q.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            act = (k < q.size()) ? q[k] : 16'hFFFF;
            check($sformatf("dfill_addr%0d", k), 64'(act), 64'(16'h1230 + 16'(2 * k)));
        end
        for (int k = 0; k < 8; k++) begin
            act = (k < wq.size()) ? 16'(wq[k]) : 16'hFFFF;
            check($sformatf("dfill_word%0d", k), 64'(act), 64'(k));
        end
        check("dfill_done_at", 64'(doneAt), 64'd11);
        check("dfill_no_i", 64'(iAct), 64'd0);

        // Tie between I and D alternates, D first.
        resetDut();
        q.delete();
        i_req = 1; i_addr = 16'h0040; d_req = 1; d_addr = 16'h8000;
        prevEn = 0; dDoneAt = -100; iFirst = -1;
        for (int n = 0; n < 60; n++) begin
            cycle();
            if (oEn && !prevEn) begin
                q.push_back(oAddr);
                if (oAddr == 16'h0040 && iFirst < 0) iFirst = cyc - 1;
            end
            prevEn = oEn;
            if (oDDone && dDoneAt < 0) dDoneAt = cyc - 1;
        end
        for (int k = 0; k < 4; k++) begin
            act = (k < q.size()) ? q[k] : 16'hFFFF;
            check($sformatf("rr_grant%0d", k), 64'(act),
                  64'((k % 2) ? 16'h0040 : 16'h8000));
        end
        check("rr_i_after_d", 64'(iFirst - dDoneAt), 64'd2);

        // Write arriving mid-fill waits for the fill.
        resetDut();
        i_req = 1; i_addr = 16'h0040;
        wRaised = 0; iDoneAt = -100; ackAt = -1; early = 0;
        ackAddr = 0; ackDin = 0; ackWr = 0;
        for (int n = 0; n < 40 && ackAt < 0; n++) begin
            cycle();
            if (oEn && !oWr && oAddr[3:1] == 3'd2 && !wRaised) begin
                w_req = 1; w_addr = 16'h0A0C; w_data = 16'hBEEF; wRaised = 1;
            end
            if (oWr && iDoneAt < 0) early++;
            if (oIDone) begin iDoneAt = cyc - 1; i_req = 0; end
            if (oAck) begin
                ackAt = cyc - 1; ackAddr = oAddr; ackDin = oDin; ackWr = oWr;
                w_req = 0;
            end
        end
        check("wmid_no_early", 64'(early), 64'd0);
        check("wmid_ack_at", 64'(ackAt - iDoneAt), 64'd2);
        check("wmid_fields", {ackWr, ackAddr, ackDin}, {1'b1, 16'h0A0C, 16'hBEEF});

        // Held d_req is not re-granted in the guard cycle.
        resetDut();
        d_req = 1; d_addr = 16'h2220; doneSeen = 0;
        for (int n = 0; n < 20 && !doneSeen; n++) begin
            cycle();
            if (oDDone) doneSeen = 1;
        end
        check("guard_done_seen", 64'(doneSeen), 64'd1);
        for (int j = 0; j < 3; j++) begin
            cycle();
            enSeen[j] = oEn;
        end
        check("guard_regrant", 64'(enSeen), 64'(3'b100));

        // Reset on receive word 4 of a D fill.
        resetDut();
        d_req = 1; d_addr = 16'h4440; doneSeen = 0;
        for (int n = 0; n < 20 && !doneSeen; n++) begin
            cycle();
            if (oDFv && oWord == 3'd3) doneSeen = 1;
        end
        check("rstmid_word3_seen", 64'(doneSeen), 64'd1);
        rst = 1; d_req = 0;
        cycle();
        rst = 0;
        cycle();
        check("rstmid_zero",
              {oEn, oWr, oAck, oIFv, oDFv, oIDone, oDDone, oWord, oAddr}, 64'd0);
        extraValid = 1;
        cycle();
        check("rstmid_late_valid", {oDFv, oDDone, oIFv, oIDone}, 64'd0);
        extraValid = 0;

        // Random traffic against the model.
        resetDut();
        pIDone = 0; pDDone = 0; pAck = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 999) == 0);
            if (i_req && pIDone) begin
                i_req = 1'($urandom_range(0, 1)); i_addr = 16'($urandom);
            end else if (!i_req && $urandom_range(0, 3) == 0) begin
                i_req = 1; i_addr = 16'($urandom);
            end
            if (d_req && pDDone) begin
                d_req = 1'($urandom_range(0, 1)); d_addr = 16'($urandom);
            end else if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req = 1; d_addr = 16'($urandom);
            end
            if (w_req && pAck) begin
                w_req = ($urandom_range(0, 3) == 0);
                w_addr = 16'($urandom); w_data = 16'($urandom);
            end else if (!w_req && $urandom_range(0, 9) == 0) begin
                w_req = 1; w_addr = 16'($urandom); w_data = 16'($urandom);
            end
            cycle();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing arbiter for the single shared `memory4c` main memory behind the instruction and data caches. It accepts block-fill requests from the I-cache and D-cache miss handlers and single-word write-through requests from the D-cache. It issues the eight pipelined word reads of a granted fill and routes the returning words, tagged with their word index, back to the granted cache. It sits between the cache-access top level and `memory4c`, replacing the ad-hoc address/enable muxing with a registered grant state machine.

## Interface
- `MEM_LATENCY`, 4 — memory read latency in cycles; bench use only. The RTL counts `mem_data_valid` and never times reads itself.
- `clk` in 1 — single clock, all state on rising edge.
- `rst` in 1 — reset is synchronous and active-high.
- `i_req` in 1 — I-cache fill request; held until `i_done`.
- `i_addr` in 16 — I-cache miss address; bits [3:0] ignored.
- `d_req` in 1 — D-cache fill request; held until `d_done`.
- `d_addr` in 16 — D-cache miss address; bits [3:0] ignored.
- `w_req` in 1 — write-through request; held until `w_ack`.
- `w_addr` in 16 — write address.
- `w_data` in 16 — write data.
- `i_busy`, `d_busy` out 1 — requester stall: `x_req & ~x_done`.
- `i_fill_valid`, `d_fill_valid` out 1 — fill word valid this cycle for that cache.
- `fill_word` out 3 — word index of `fill_data`.
- `fill_data` out 16 — returning word (`mem_data_out` passthrough).
- `i_done`, `d_done` out 1 — one-cycle pulse with the 8th word.
- `w_ack` out 1 — one-cycle pulse in the cycle the write is issued.
- `mem_addr` out 16, `mem_data_in` out 16, `mem_enable` out 1, `mem_wr` out 1 — to `memory4c`.
- `mem_data_out` in 16, `mem_data_valid` in 1 — from `memory4c`.

## Operation
- States: IDLE, WRITE, FILL_I, FILL_D.
- IDLE: arbitrate among eligible requests; the winner is registered and the next state is set.
  - Priority: `w_req` > fills.
  - Between `i_req` and `d_req`: round-robin on `last_fill` (0=D, 1=I). The fill not granted last wins a tie. `last_fill` resets to 1, so D wins the first tie.
- WRITE: lasts one cycle.
  - `mem_enable=1`, `mem_wr=1`, `mem_addr=w_addr`, `mem_data_in=w_data`, `w_ack=1`.
  - Next state IDLE.
- FILL_x: `base = x_addr[15:4]` latched at grant.
  - Issue counter `iss` (4 bits) issues reads on consecutive cycles: `mem_enable=1`, `mem_wr=0`, `mem_addr={base, iss[2:0], 1'b0}` for `iss` = 0..7, then stops.
  - Receive counter `rcv` (3 bits) increments on each `mem_data_valid`. `fill_word=rcv` and `x_fill_valid=mem_data_valid`.
  - On the valid with `rcv==7`: `x_done=1`, counters clear, `last_fill` updates, next state IDLE.
- No preemption: a fill runs to completion. `w_req` arriving mid-fill waits and is granted on the next IDLE.
- Guard: in the IDLE cycle after `x_done`, requester x is ineligible, since its req may still be high while the cache registers the fill. Other requesters may be granted in that cycle.
- `mem_data_valid` in IDLE or WRITE is ignored: no fill_valid is raised and no counter moves.
- `mem_data_in` drives `w_data` in all states; it is don't-care when `mem_wr=0`.

## Timing
- Reset values: state IDLE, counters 0, `last_fill=1`, and all outputs 0 (`mem_*`, `*_fill_valid`, `*_done`, `w_ack`, `fill_word`). `fill_data` follows `mem_data_out`. `x_busy` follows `x_req`.
- Reset mid-fill: everything returns to reset values the next cycle. In-flight returns are dropped, because `memory4c` shares `rst`.
- Fill: request seen in IDLE at cycle T. Reads are issued at T+1..T+8.
  - Word k valid at T+1+k+MEM_LATENCY-1 (memory4c convention). `x_done` at T+8+MEM_LATENCY-1, i.e. T+11 for latency 4.
  - Back-to-back fills: the next grant is in the IDLE cycle after done, so reads resume 2 cycles after done.
- Write: requested in IDLE at T → `w_ack` and the memory write at T+1. Throughput is one write per 2 cycles.
- Simultaneous `w_req`, `i_req`, `d_req` in IDLE: write first, then D (if `last_fill=1`), then I.

## Test plan
- Reset, then `d_req=1`, `d_addr=0x1234`.
  - Required: `mem_addr` = 0x1230, 0x1232, …, 0x123E on 8 consecutive cycles.
  - `d_fill_valid` ×8 with `fill_word` 0..7, `d_done` at T+11. No `i_*` activity.
- `i_req`, `d_req` both high from reset, addresses 0x0040 and 0x8000.
  - Required: D fill completes first, I fill granted the cycle after `d_done`.
  - Repeat the tie: I now loses to… D alternates correctly (round-robin).
- `w_req` (0x0A0C, 0xBEEF) raised at issue cycle 3 of an I fill.
  - Required: no write until fill done. `w_ack` with `mem_wr=1`, `mem_addr=0x0A0C`, `mem_data_in=0xBEEF` in the IDLE+1 cycle after `i_done`.
- `d_req` held high through the cycle after `d_done`.
  - Required: no re-grant in the guard cycle. Re-grant only if still high one cycle later.
- Assert `rst` at receive word 4 of a D fill.
  - Required: next cycle all outputs 0, state IDLE. A late `mem_data_valid` produces no `d_fill_valid`.
- Stray `mem_data_valid=1` in IDLE → no fill_valid or done.
